// File: rtl/seg7_scan_decoder.sv
// Seven-segment scan reader: filters a multiplexed active-low segment bus and
// streams decoded digits. Define SEG7_SCAN_CHANGE_ONLY_EN to emit only on change.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4,
  parameter int DIG_W         = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            seven_seg_in,
  input  logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIG_W-1:0]      out_digit,
  output logic [3:0]            out_number,
  output logic                  out_dp,
  output logic                  out_blank,
  output logic                  out_error,
  output logic                  overflow,
  input  logic                  clr_overflow
);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

  localparam logic [3:0] STABLE_CNT = 4'(STABLE_CYCLES);

  logic [7:0]            s_seg_q, prev_seg_q;
  logic [NUM_DIGITS-1:0] s_sel_q, prev_sel_q;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  lock;
  logic                  sel_onehot, same;
  logic [DIG_W-1:0]      sel_idx;
  logic [3:0]            dec_number;
  logic                  dec_blank, dec_error;

  logic                  commit_q, commit_d;
  logic [DIG_W-1:0]      c_digit_q, c_digit_d;
  logic [3:0]            c_number_q, c_number_d;
  logic                  c_dp_q, c_dp_d, c_blank_q, c_blank_d, c_error_q, c_error_d;

  logic                  out_valid_q, out_valid_d;
  logic [DIG_W-1:0]      out_digit_q, out_digit_d;
  logic [3:0]            out_number_q, out_number_d;
  logic                  out_dp_q, out_dp_d, out_blank_q, out_blank_d, out_error_q, out_error_d;
  logic                  overflow_q, overflow_d;
  logic                  emit;

`ifdef SEG7_SCAN_CHANGE_ONLY_EN
  logic [7:0]            shadow_q [NUM_DIGITS];
  logic [7:0]            shadow_d [NUM_DIGITS];
  logic [7:0]            c_entry;
`endif

  always_comb begin
    sel_onehot = $onehot(s_sel_q);
    same       = ({s_sel_q, s_seg_q} == {prev_sel_q, prev_seg_q});
    sel_idx    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (s_sel_q[i]) sel_idx = DIG_W'(i);
    end
  end

  always_comb begin
    dec_number = 4'h0;
    dec_blank  = 1'b0;
    dec_error  = 1'b0;
    case (s_seg_q[6:0])
      7'h40: dec_number = 4'h0;
      7'h79: dec_number = 4'h1;
      7'h24: dec_number = 4'h2;
      7'h30: dec_number = 4'h3;
      7'h19: dec_number = 4'h4;
      7'h12: dec_number = 4'h5;
      7'h02: dec_number = 4'h6;
      7'h78: dec_number = 4'h7;
      7'h00: dec_number = 4'h8;
      7'h10: dec_number = 4'h9;
      7'h08: dec_number = 4'hA;
      7'h03: dec_number = 4'hB;
      7'h46: dec_number = 4'hC;
      7'h21: dec_number = 4'hD;
      7'h06: dec_number = 4'hE;
      7'h0E: dec_number = 4'hF;
      7'h7F: dec_blank  = 1'b1;
      default: dec_error = 1'b1;
    endcase
  end

  // The first one-hot sample counts as 1; lock fires when the count reaches STABLE_CYCLES.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lock    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (sel_onehot) begin
          state_d = TRACK;
          cnt_d   = 4'd1;
        end
      end
      TRACK: begin
        if (!sel_onehot) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (!same) begin
          cnt_d = 4'd1;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == STABLE_CNT) begin
            state_d = LOCKED;
            lock    = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (!sel_onehot) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (!same) begin
          state_d = TRACK;
          cnt_d   = 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    commit_d   = lock;
    c_digit_d  = c_digit_q;
    c_number_d = c_number_q;
    c_dp_d     = c_dp_q;
    c_blank_d  = c_blank_q;
    c_error_d  = c_error_q;
    if (lock) begin
      c_digit_d  = sel_idx;
      c_number_d = dec_number;
      c_dp_d     = ~s_seg_q[7];
      c_blank_d  = dec_blank;
      c_error_d  = dec_error;
    end
  end

  // A dropped event leaves the shadow untouched so the next scan regenerates it.
  always_comb begin
`ifdef SEG7_SCAN_CHANGE_ONLY_EN
    c_entry  = {c_number_q, c_dp_q, c_blank_q, c_error_q, 1'b1};
    emit     = commit_q && (shadow_q[c_digit_q] != c_entry);
    shadow_d = shadow_q;
`else
    emit     = commit_q;
`endif
    out_valid_d  = out_valid_q;
    out_digit_d  = out_digit_q;
    out_number_d = out_number_q;
    out_dp_d     = out_dp_q;
    out_blank_d  = out_blank_q;
    out_error_d  = out_error_q;
    overflow_d   = overflow_q && !clr_overflow;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (emit) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d  = 1'b1;
        out_digit_d  = c_digit_q;
        out_number_d = c_number_q;
        out_dp_d     = c_dp_q;
        out_blank_d  = c_blank_q;
        out_error_d  = c_error_q;
`ifdef SEG7_SCAN_CHANGE_ONLY_EN
        shadow_d[c_digit_q] = c_entry;
`endif
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_seg_q      <= '0;
      s_sel_q      <= '0;
      prev_seg_q   <= '0;
      prev_sel_q   <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      commit_q     <= 1'b0;
      c_digit_q    <= '0;
      c_number_q   <= '0;
      c_dp_q       <= 1'b0;
      c_blank_q    <= 1'b0;
      c_error_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_digit_q  <= '0;
      out_number_q <= '0;
      out_dp_q     <= 1'b0;
      out_blank_q  <= 1'b0;
      out_error_q  <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef SEG7_SCAN_CHANGE_ONLY_EN
      shadow_q     <= '{default: '0};
`endif
    end else begin
      s_seg_q      <= seven_seg_in;
      s_sel_q      <= digit_sel;
      prev_seg_q   <= s_seg_q;
      prev_sel_q   <= s_sel_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      commit_q     <= commit_d;
      c_digit_q    <= c_digit_d;
      c_number_q   <= c_number_d;
      c_dp_q       <= c_dp_d;
      c_blank_q    <= c_blank_d;
      c_error_q    <= c_error_d;
      out_valid_q  <= out_valid_d;
      out_digit_q  <= out_digit_d;
      out_number_q <= out_number_d;
      out_dp_q     <= out_dp_d;
      out_blank_q  <= out_blank_d;
      out_error_q  <= out_error_d;
      overflow_q   <= overflow_d;
`ifdef SEG7_SCAN_CHANGE_ONLY_EN
      shadow_q     <= shadow_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign out_digit  = out_digit_q;
  assign out_number = out_number_q;
  assign out_dp     = out_dp_q;
  assign out_blank  = out_blank_q;
  assign out_error  = out_error_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed self-checking bench for seg7_scan_decoder; events accepted by the
// consumer are captured into a queue and compared against hand-computed values.
module tb_seg7_scan_decoder;

  logic       clk;
  logic       reset;
  logic [7:0] seven_seg_in;
  logic [5:0] digit_sel;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_digit;
  logic [3:0] out_number;
  logic       out_dp;
  logic       out_blank;
  logic       out_error;
  logic       overflow;
  logic       clr_overflow;

  int checks   = 0;
  int failures = 0;

  logic [9:0] ev_q [$];

  seg7_scan_decoder #(.NUM_DIGITS(6), .STABLE_CYCLES(4), .DIG_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .seven_seg_in (seven_seg_in),
    .digit_sel    (digit_sel),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_digit    (out_digit),
    .out_number   (out_number),
    .out_dp       (out_dp),
    .out_blank    (out_blank),
    .out_error    (out_error),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every event the consumer accepts on the following rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready)
      ev_q.push_back({out_error, out_blank, out_dp, out_number, out_digit});
  end

  function automatic logic [9:0] ev(input logic err, input logic blank, input logic dp,
                                    input logic [3:0] num, input logic [2:0] dig);
    return {err, blank, dp, num, dig};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] sel, input logic [7:0] seg, input int cycles);
    digit_sel    = sel;
    seven_seg_in = seg;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] sweep_seg [20];
  logic [2:0] sweep_dig [20];
  logic [9:0] sweep_exp [20];
  int         n_change;
  logic [9:0] entry;

  initial begin
    sweep_seg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90,
                  8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E, 8'h7F, 8'hFF, 8'h7E, 8'h40};
    for (int i = 0; i < 18; i++) sweep_dig[i] = 3'(i % 6);
    sweep_dig[18] = 3'd0;
    sweep_dig[19] = 3'd1;
    for (int i = 0; i < 16; i++) sweep_exp[i] = ev(1'b0, 1'b0, 1'b0, 4'(i), sweep_dig[i]);
    sweep_exp[16] = ev(1'b0, 1'b1, 1'b1, 4'h0, 3'd4);
    sweep_exp[17] = ev(1'b0, 1'b1, 1'b0, 4'h0, 3'd5);
    sweep_exp[18] = ev(1'b1, 1'b0, 1'b1, 4'h0, 3'd0);
    sweep_exp[19] = ev(1'b0, 1'b0, 1'b1, 4'h0, 3'd1);

    reset        = 1'b1;
    digit_sel    = '0;
    seven_seg_in = 8'hFF;
    out_ready    = 1'b1;
    clr_overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    checkOutput("reset_digit", 32'(out_digit), 32'd0);
    checkOutput("reset_number", 32'(out_number), 32'd0);
    checkOutput("reset_dp", 32'(out_dp), 32'd0);
    checkOutput("reset_blank", 32'(out_blank), 32'd0);
    checkOutput("reset_error", 32'(out_error), 32'd0);
    reset = 1'b0;

    $display("[TB] stable pattern latency");
    digit_sel    = 6'b000001;
    seven_seg_in = 8'hC0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("latency_valid_edge%0d", k), 32'(out_valid), 32'(k == 6));
      if (k == 6)
        checkOutput("latency_event", 32'({out_error, out_blank, out_dp, out_number, out_digit}),
                    32'(ev(1'b0, 1'b0, 1'b0, 4'h0, 3'd0)));
    end
    checkOutput("latency_event_count", 32'(ev_q.size()), 32'd1);
    applyStimulus(6'b000000, 8'hFF, 2);
    ev_q.delete();

    $display("[TB] glitch rejection");
    for (int k = 0; k < 10; k++) applyStimulus(6'b000100, (k % 2 == 0) ? 8'h99 : 8'h92, 2);
    checkOutput("glitch_no_event", 32'(ev_q.size()), 32'd0);
    applyStimulus(6'b000100, 8'h92, 8);
    checkOutput("glitch_event_count", 32'(ev_q.size()), 32'd1);
    checkOutput("glitch_event", 32'(ev_q[0]), 32'(ev(1'b0, 1'b0, 1'b0, 4'h5, 3'd2)));
    applyStimulus(6'b000000, 8'hFF, 2);
    ev_q.delete();

    $display("[TB] table sweep");
    for (int i = 0; i < 20; i++) applyStimulus(6'(1 << sweep_dig[i]), sweep_seg[i], 6);
    applyStimulus(6'b000000, 8'hFF, 4);
    checkOutput("sweep_event_count", 32'(ev_q.size()), 32'd20);
    for (int i = 0; i < 20; i++)
      checkOutput($sformatf("sweep_%0d_seg%0h", i, sweep_seg[i]), 32'(ev_q[i]), 32'(sweep_exp[i]));
    checkOutput("sweep_no_overflow", 32'(overflow), 32'd0);
    ev_q.delete();

    $display("[TB] backpressure and overflow");
    out_ready = 1'b0;
    applyStimulus(6'b000010, 8'hF9, 8);
    applyStimulus(6'b001000, 8'hA4, 8);
    checkOutput("bp_valid_held", 32'(out_valid), 32'd1);
    checkOutput("bp_event_held", 32'({out_error, out_blank, out_dp, out_number, out_digit}),
                32'(ev(1'b0, 1'b0, 1'b0, 4'h1, 3'd1)));
    checkOutput("bp_overflow_set", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    applyStimulus(6'b000000, 8'hFF, 2);
    applyStimulus(6'b001000, 8'hA4, 8);
    checkOutput("bp_event_count", 32'(ev_q.size()), 32'd2);
    checkOutput("bp_first_event", 32'(ev_q[0]), 32'(ev(1'b0, 1'b0, 1'b0, 4'h1, 3'd1)));
    checkOutput("bp_regen_event", 32'(ev_q[1]), 32'(ev(1'b0, 1'b0, 1'b0, 4'h2, 3'd3)));
    checkOutput("bp_overflow_sticky", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    @(posedge clk);
    #1;
    clr_overflow = 1'b0;
    checkOutput("bp_overflow_cleared", 32'(overflow), 32'd0);
    ev_q.delete();

    $display("[TB] change-only rescans");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(6'b000000, 8'hFF, 2);
      applyStimulus(6'b010000, 8'hB0, 8);
    end
    applyStimulus(6'b000000, 8'hFF, 2);
    applyStimulus(6'b010000, 8'h30, 8);
    applyStimulus(6'b000000, 8'hFF, 2);
`ifdef SEG7_SCAN_CHANGE_ONLY_EN
    n_change = 2;
`else
    n_change = 4;
`endif
    checkOutput("rescan_event_count", 32'(ev_q.size()), 32'(n_change));
    checkOutput("rescan_first_event", 32'(ev_q[0]), 32'(ev(1'b0, 1'b0, 1'b0, 4'h3, 3'd4)));
    entry = ev_q[n_change - 1];
    checkOutput("rescan_last_event", 32'(entry), 32'(ev(1'b0, 1'b0, 1'b1, 4'h3, 3'd4)));
    ev_q.delete();

    $display("[TB] reset mid-operation");
    out_ready = 1'b0;
    applyStimulus(6'b100000, 8'h92, 8);
    applyStimulus(6'b000001, 8'hC0, 8);
    checkOutput("mid_valid_before", 32'(out_valid), 32'd1);
    checkOutput("mid_overflow_before", 32'(overflow), 32'd1);
    applyStimulus(6'b100000, 8'h92, 3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("mid_valid_after_reset", 32'(out_valid), 32'd0);
    checkOutput("mid_overflow_after_reset", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    ev_q.delete();
    applyStimulus(6'b100000, 8'h92, 8);
    checkOutput("mid_reemit_count", 32'(ev_q.size()), 32'd1);
    checkOutput("mid_reemit_event", 32'(ev_q[0]), 32'(ev(1'b0, 1'b0, 1'b0, 4'h5, 3'd5)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Reader side of the board's 8-bit active-low seven-segment encoding.
- Samples a multiplexed segment bus plus a one-hot digit strobe, filters glitches, and decodes each stable pattern back to a 4-bit hex value.
- Reports each result through a valid/ready stream.
- Used as a loop-back checker on display outputs and as a front-end for scraping external seven-segment modules into the Nios system.

Parameters:
- NUM_DIGITS, 6: number of multiplexed digits; width of digit_sel.
- STABLE_CYCLES, 4: consecutive identical samples required before a pattern is accepted; legal range 2..15.
- DIG_W, 3: width of the digit index; must be ≥ clog2(NUM_DIGITS).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- seven_seg_in  in  8  segment bus, active-low; bit7 = DP, bits6..0 = g..a
- digit_sel  in  NUM_DIGITS  one-hot, active-high digit strobe
- out_valid  out  1  decoded event available
- out_ready  in  1  consumer accepts the event when out_valid && out_ready
- out_digit  out  DIG_W  digit index of the event
- out_number  out  4  decoded hex value; 0 when blank or error
- out_dp  out  1  decimal point lit (active-high)
- out_blank  out  1  all of segments a..g off
- out_error  out  1  unrecognised pattern
- overflow  out  1  sticky: an event was dropped
- clr_overflow  in  1  synchronous clear of overflow

Behaviour:
- Reset values:
  - out_valid = 0, overflow = 0.
  - out_digit, out_number, out_dp, out_blank, out_error all 0.
  - State = IDLE, stability counter = 0, all shadow entries invalid.
- Input stage:
  - seven_seg_in and digit_sel are registered once (s_seg, s_sel).
  - All decisions use these registered values.
- Decode table, on s_seg[6:0] hex:
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F.
  - 7F → blank.
  - Any other value → error.
  - out_dp = ~s_seg[7], independent of the above.
- State machine:
  - IDLE: s_sel not exactly one-hot (zero or multiple bits). Counter held at 0. Go to TRACK when s_sel is one-hot.
  - TRACK: counter increments each cycle that {s_sel, s_seg} equals the previous cycle's value; any change reloads the counter to 1. When the counter reaches STABLE_CYCLES, go to LOCKED and generate one commit.
  - LOCKED: no further commits. Any change of {s_sel, s_seg} → TRACK with counter = 1; non-one-hot s_sel → IDLE.
- Latency: with inputs held constant, out_valid rises on the (STABLE_CYCLES+2)th rising edge after the first edge that sees the new value.
  - 1 cycle input register.
  - STABLE_CYCLES cycles of filtering.
  - 1 cycle output register.
- Commit:
  - Decode, then compare with shadow[digit] = {number, dp, blank, error, valid}.
  - Produce an event only as defined under Optional Feature.
  - An event loads the output register and updates shadow[digit].
- Handshake:
  - Single-entry output register; out_* fields are stable while out_valid is high.
  - Transfer occurs on out_valid && out_ready.
  - A commit on the same cycle as a transfer loads the new event (no bubble).
  - A commit while out_valid && !out_ready:
    - drops the event;
    - sets overflow;
    - leaves shadow[digit] unchanged, so the next scan of that digit regenerates the event.
- overflow:
  - Cleared only by reset or clr_overflow.
  - If a set and a clear occur on the same cycle, set wins.
- Reset mid-operation clears any pending event and all shadow entries; the first lock after reset always emits.

Optional Feature:
- Macro: SEG7_SCAN_CHANGE_ONLY_EN.
- Defined:
  - Commit emits only if shadow[digit] is invalid or differs in any field.
  - Rescans of an unchanged digit are silent.
- Undefined:
  - Every commit emits an event.
  - Shadow registers are not built.
  - Overflow then arises whenever the consumer is slower than the scan rate.

Test Plan:
- Stable glitch-free pattern:
  - Stimulus: reset, then digit_sel=000001, seven_seg_in=8'hC0 held 10 cycles, out_ready=1.
  - Response: exactly one event on edge 6 after the first drive, with out_digit=0, number=0, dp=0, blank=0, error=0.
- Glitch rejection:
  - Stimulus: digit_sel=000100, seg toggles 8'h99/8'h92 every 2 cycles for 20 cycles, then holds 8'h92.
  - Response: no event during toggling; one event with digit=2, number=5.
- Full table sweep:
  - Stimulus: scan all 16 patterns plus 8'h7F and 8'hFF across digits 0..5.
  - Response: 0..F decoded correctly; 7F and FF give blank=1; 8'h7E gives error=1 and number=0; 8'h40 gives dp=1, number=0.
- Backpressure and overflow:
  - Stimulus: out_ready=0; digit 1 locks 8'hF9, then digit 3 locks 8'hA4.
  - Response: first event (digit=1, number=1) held stable; overflow=1. With ready=1, the digit 3 event (number=2) appears on its next scan. clr_overflow pulse clears overflow to 0.
- Change-only (SEG7_SCAN_CHANGE_ONLY_EN):
  - Stimulus: rescan digit 4 with 8'hB0 three times, then 8'hB0 with DP low (8'h30).
  - Response: with macro defined, 2 events (number=3, dp=0; then dp=1). Without the macro, 4 events.
- Reset mid-operation:
  - Stimulus: assert reset while out_valid=1 and the counter is at 2.
  - Response: next cycle out_valid=0 and overflow=0; rescanning the same value emits again.
